// File: rtl/psum_collector_if.sv
// Stream bundle between a PE column drain and its result consumer.
// The collector is the slave: it consumes partial sums and produces results.
interface psum_collector_if #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PSUM_W-1:0] in_psum;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;

    modport master (
        output in_valid, in_psum, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_psum, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_collector.sv
// Accumulates a programmed number of PE_sum beats per result with saturation,
// queues results in a small FIFO and streams them out; one job at a time.
module psum_collector #(
    parameter int PSUM_W     = 20,
    parameter int ACC_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_passes,
    input  logic [CNT_W-1:0] cfg_outputs,
    psum_collector_if.slave  bus,
    output logic             busy,
    output logic             done,
    output logic             sat_flag
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  r_state;
    logic [CNT_W-1:0]        r_passes;
    logic [CNT_W-1:0]        r_outputs;
    logic [CNT_W-1:0]        r_pass_cnt;
    logic [CNT_W-1:0]        r_out_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_sat;

    logic signed [ACC_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W:0]          r_count;

    logic [CNT_W-1:0]        w_cfg_passes;
    logic [CNT_W-1:0]        w_cfg_outputs;
    logic                    w_final;
    logic                    w_last_out;
    logic                    w_in_ready;
    logic                    w_beat;
    logic                    w_push;
    logic                    w_pop;
    logic signed [ACC_W:0]   w_sum_wide;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_sum_sat;

    assign w_cfg_passes  = (cfg_passes  == '0) ? CNT_W'(1) : cfg_passes;
    assign w_cfg_outputs = (cfg_outputs == '0) ? CNT_W'(1) : cfg_outputs;

    assign w_final    = (r_pass_cnt == r_passes - CNT_W'(1));
    assign w_last_out = (r_out_cnt == r_outputs - CNT_W'(1));

    // Space is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign w_in_ready = (r_state == S_ACCUM) && (!w_final || (r_count != FULL_CNT));
    assign w_beat     = bus.in_valid && w_in_ready;
    assign w_push     = w_beat && w_final;
    assign w_pop      = (r_count != '0) && bus.out_ready;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign w_sum_wide = {r_acc[ACC_W-1], r_acc}
                      + {{(ACC_W+1-PSUM_W){bus.in_psum[PSUM_W-1]}}, bus.in_psum};
    assign w_ovf      = (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]);
    assign w_sum_sat  = !w_ovf             ? w_sum_wide[ACC_W-1:0] :
                        w_sum_wide[ACC_W]  ? ACC_MIN : ACC_MAX;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_passes   <= '0;
            r_outputs  <= '0;
            r_pass_cnt <= '0;
            r_out_cnt  <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_passes   <= w_cfg_passes;
                        r_outputs  <= w_cfg_outputs;
                        r_pass_cnt <= '0;
                        r_out_cnt  <= '0;
                        r_acc      <= '0;
                        r_sat      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        if (w_ovf) begin
                            r_sat <= 1'b1;
                        end
                        if (w_final) begin
                            r_acc      <= '0;
                            r_pass_cnt <= '0;
                            r_out_cnt  <= r_out_cnt + CNT_W'(1);
                            if (w_last_out) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_acc      <= w_sum_sat;
                            r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage is reset too, so out_data reads 0 after reset and a mid-job reset flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_sum_sat;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign busy          = r_busy;
    assign done          = r_done;
    assign sat_flag      = r_sat;
endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits at the drain end of a PE column and consumes the 20-bit signed PE_sum chain output.
- Accumulates a programmed number of consecutive partial sums (temporal passes) into one wide result and buffers results in a small FIFO.
- Streams results out over a valid/ready interface.
- Runs jobs of a programmed output count and signals completion once everything has drained.

Parameters:
PSUM_W, 20, width of incoming signed partial sum
ACC_W, 32, width of signed accumulator and output word
FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)
CNT_W, 8, width of pass and output counters

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  one-cycle pulse, begins a job; ignored unless idle
cfg_passes  in  CNT_W  partial sums per result; 0 treated as 1; sampled on accepted start
cfg_outputs  in  CNT_W  results per job; 0 treated as 1; sampled on accepted start
in_valid  in  1  partial sum present
in_ready  out  1  collector accepts in_psum this cycle
in_psum  in  PSUM_W  signed partial sum (PE_sum)
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_data  out  ACC_W  signed accumulated result
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when job complete and FIFO empty
sat_flag  out  1  sticky, any result saturated this job

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state clears immediately on rst_n low.
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, sat_flag=0; FIFO empty; accumulator and counters 0; state IDLE.
- States:
  - IDLE: start pulse latches cfg_passes/cfg_outputs (0 mapped to 1), clears accumulator, counters and sat_flag, sets busy, goes to ACCUM.
  - ACCUM: accepts partial sums. After the beat that completes the last pass of the last output, goes to DRAIN.
  - DRAIN: in_ready=0. When FIFO is empty, pulses done for one cycle, clears busy, returns to IDLE. done and FIFO-empty are evaluated on registered state, so done appears no earlier than the cycle after the last pop.
- Beat handling:
  - Beat = in_valid & in_ready.
  - in_psum is sign-extended to ACC_W.
  - Non-final beat: acc <= sat(acc + ext(in_psum)); pass_cnt increments.
  - Final beat (pass_cnt == passes-1): sat(acc + ext(in_psum)) is pushed into the FIFO; acc <= 0; pass_cnt <= 0; out_cnt increments.
- in_ready = (state==ACCUM) & (!final_pass | fifo_count < FIFO_DEPTH). A pop in the same cycle does not free space for a push; a full FIFO blocks the final beat.
- Saturation:
  - Sum is computed at ACC_W+1 bits.
  - Result above max clamps to 2^(ACC_W-1)-1; below min clamps to -2^(ACC_W-1).
  - Any clamp sets sat_flag until the next accepted start.
- FIFO:
  - Registered, no fall-through; out_data/out_valid are driven from the head register.
  - First result becomes visible the cycle after its final beat (latency 1).
  - Pop = out_valid & out_ready.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pop on empty is a no-op.
  - out_data holds its value while out_valid=0 or out_ready=0.
- start while busy is ignored; no cfg change takes effect mid-job.
- Pointer wrap-around uses modulo FIFO_DEPTH indexing plus a separate count.
- Asserting rst_n low mid-job aborts it: FIFO flushed, no done pulse.

Test Plan:
1. passes=4, outputs=2; psums 1,2,3,4,-5,-6,-7,-8 back-to-back, out_ready=1 -> out_data 10 one cycle after beat 4, then -26; done pulses once, busy falls with it.
2. passes=0, outputs=0 -> treated as 1/1; single psum 0x7FFFF -> out_data 524287; psum 0x80000 -> -524288 (sign extension check).
3. passes=1, outputs=6, out_ready=0 -> 4 results accepted, in_ready drops on 5th; raise out_ready for one cycle -> in_ready returns the cycle after the pop, not the same cycle; all 6 results delivered in order.
4. ACC_W=20 build, passes=2; psums 0x7FFFF,0x00001 -> out_data 0x7FFFF, sat_flag=1; next start clears sat_flag.
5. Assert rst_n low mid-ACCUM with 2 FIFO entries -> out_valid, busy, in_ready 0 immediately; no done; a new job runs cleanly afterwards.
6. start pulsed during DRAIN and ACCUM -> ignored, cfg unchanged, output counts match the original job.
